ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader_pkg.sv | 19 +
 rtl/ccff_loader_ser.sv | 49 ++++
 rtl/ccff_loader.sv | 118 +++++++++++
 tb/tb_ccff_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared fabric-config constants and loader state encoding
package ccff_loader_pkg;

    localparam int DEF_CHAIN_LEN = 42;
    localparam int DEF_WORD_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccff_loader_ser.sv
// rtl/ccff_loader_ser.sv - word-to-bit serializer with in-word index and chain bit counter
module ccff_loader_ser
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           load,
    input  logic [WORD_W-1:0]              data,
    input  logic                           step,
    output logic                           bit_out,
    output logic [cnt_w(CHAIN_LEN)-1:0]    bit_cnt,
    output logic                           last_word_bit,
    output logic                           last_chain_bit
);

    localparam int CW = cnt_w(CHAIN_LEN);
    localparam int IW = cnt_w(WORD_W);

    logic [WORD_W-1:0] sreg;
    logic [IW-1:0]     widx;

    assign bit_out        = sreg[0];
    assign last_word_bit  = (widx == IW'(WORD_W - 1));
    assign last_chain_bit = (bit_cnt == CW'(CHAIN_LEN - 1));

    // The chain counter wraps so the verify pass reuses it as its cycle index.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            widx    <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            widx    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sreg <= data;
            widx <= '0;
        end else if (step) begin
            sreg    <= sreg >> 1;
            widx    <= last_word_bit ? '0 : widx + 1'b1;
            bit_cnt <= last_chain_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - configuration-chain loader with optional recirculating readback verify
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = cnt_w(CHAIN_LEN);

    state_t               state;
    state_t               state_nx;
    logic                 verify_q;
    logic                 err_q;
    logic [CHAIN_LEN-1:0] shadow;

    logic                 ser_clear;
    logic                 ser_load;
    logic                 ser_step;
    logic                 ser_bit;
    logic [CW-1:0]        bit_cnt;
    logic                 last_word_bit;
    logic                 last_chain_bit;

    assign ser_clear = (state == ST_IDLE) && cfg_start;
    assign ser_load  = (state == ST_FETCH) && cfg_valid;
    assign ser_step  = (state == ST_SHIFT) || (state == ST_VERIFY);
    assign err       = err_q;

    ccff_loader_ser #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_ser (
        .clk            (prog_clk),
        .rst            (pReset),
        .clear          (ser_clear),
        .load           (ser_load),
        .data           (cfg_data),
        .step           (ser_step),
        .bit_out        (ser_bit),
        .bit_cnt        (bit_cnt),
        .last_word_bit  (last_word_bit),
        .last_chain_bit (last_chain_bit)
    );

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state    <= ST_IDLE;
            verify_q <= 1'b0;
            err_q    <= 1'b0;
            shadow   <= '0;
        end else begin
            state <= state_nx;
            if (ser_clear) begin
                verify_q <= verify_en;
                err_q    <= 1'b0;
            end
            if (state == ST_SHIFT) begin
                shadow[bit_cnt] <= ser_bit;
            end
            if ((state == ST_VERIFY) && (ccff_tail != shadow[bit_cnt])) begin
                err_q <= 1'b1;
            end
        end
    end

    // In SHIFT, head and shift_en decode only flops, so both move on the same edge;
    // in VERIFY the head is a straight loop-back of the tail.
    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        shift_en  = 1'b0;
        ccff_head = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (cfg_start) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_en  = 1'b1;
                ccff_head = ser_bit;
                if (last_chain_bit)     state_nx = verify_q ? ST_VERIFY : ST_FINISH;
                else if (last_word_bit) state_nx = ST_FETCH;
            end
            ST_VERIFY: begin
                shift_en  = 1'b1;
                ccff_head = ccff_tail;
                if (last_chain_bit) state_nx = ST_FINISH;
            end
            ST_FINISH: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - table-driven and randomized bench for ccff_loader against a chain model
module tb_ccff_loader;

    localparam int N  = 42;
    localparam int W  = 8;
    localparam int NW = (N + W - 1) / W;

    logic          prog_clk = 1'b0;
    logic          pReset = 1'b1;
    logic          cfg_start = 1'b0;
    logic          verify_en = 1'b0;
    logic [W-1:0]  cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready, ccff_head, ccff_tail, shift_en, busy, done, err;

    logic          cfg_start8 = 1'b0;
    logic [7:0]    cfg_data8 = '0;
    logic          cfg_valid8 = 1'b0;
    logic          cfg_ready8, ccff_head8, ccff_tail8, shift_en8, busy8, done8, err8;

    always #5 prog_clk = ~prog_clk;

    ccff_loader #(.CHAIN_LEN(N), .WORD_W(W)) dut (
        .prog_clk (prog_clk), .pReset (pReset), .cfg_start (cfg_start),
        .verify_en (verify_en), .cfg_data (cfg_data), .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready), .ccff_head (ccff_head), .ccff_tail (ccff_tail),
        .shift_en (shift_en), .busy (busy), .done (done), .err (err)
    );

    ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
        .prog_clk (prog_clk), .pReset (pReset), .cfg_start (cfg_start8),
        .verify_en (1'b0), .cfg_data (cfg_data8), .cfg_valid (cfg_valid8),
        .cfg_ready (cfg_ready8), .ccff_head (ccff_head8), .ccff_tail (ccff_tail8),
        .shift_en (shift_en8), .busy (busy8), .done (done8), .err (err8)
    );

    // Chain model: head side at bit 0, tail at bit N-1; fault_at inverts the tail for one shift.
    logic [N-1:0] chain = '0;
    int           pos_cnt = 0;
    int           fault_at = -1;
    assign ccff_tail = chain[N-1] ^ ((fault_at >= 0) && (pos_cnt == fault_at));

    always @(posedge prog_clk) begin
        if (shift_en) begin
            chain   <= {chain[N-2:0], ccff_head};
            pos_cnt <= pos_cnt + 1;
        end
    end

    int   cyc = 0, neg_shift = 0, words_in = 0, dones = 0, done_cyc = 0, last_shift_cyc = 0;
    logic err_at_done = 1'b0;
    always @(negedge prog_clk) begin
        cyc <= cyc + 1;
        if (shift_en) begin
            neg_shift      <= neg_shift + 1;
            last_shift_cyc <= cyc;
        end
        if (cfg_valid && cfg_ready) words_in <= words_in + 1;
        if (done) begin
            dones       <= dones + 1;
            done_cyc    <= cyc;
            err_at_done <= err;
        end
    end

    logic [7:0] chain8 = '0;
    int         shifts8 = 0, words8 = 0, dones8 = 0;
    assign ccff_tail8 = chain8[7];
    always @(posedge prog_clk) if (shift_en8) chain8 <= {chain8[6:0], ccff_head8};
    always @(negedge prog_clk) begin
        if (shift_en8) shifts8 <= shifts8 + 1;
        if (cfg_valid8 && cfg_ready8) words8 <= words8 + 1;
        if (done8) dones8 <= dones8 + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Bit k of the LSB-first word stream must end up k positions back from the tail.
    function automatic logic [N-1:0] exp_image(input logic [NW*W-1:0] words);
        logic [N-1:0] img;
        for (int k = 0; k < N; k++) img[N-1-k] = words[(k / W) * W + (k % W)];
        return img;
    endfunction

    typedef struct {
        logic [NW*W-1:0] words;
        bit              ver;
        int              fault_k;
        int              stall_idx;
        int              stall_len;
        bit              start_mid;
        int              exp_shifts;
        bit              exp_err;
    } vec_t;

    task automatic run_session(input vec_t v, input string tag);
        int base_shift, base_words, base_dones, to;
        base_shift = neg_shift;
        base_words = words_in;
        base_dones = dones;
        fault_at   = (v.fault_k >= 0) ? pos_cnt + N + v.fault_k : -1;
        cfg_start  = 1'b1;
        verify_en  = v.ver;
        tick();
        cfg_start  = 1'b0;
        verify_en  = 1'($urandom);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_err_clr"}, 64'(err), 64'd0);
        for (int i = 0; i < NW; i++) begin
            to = 0;
            while (!cfg_ready && to < 200) begin
                tick();
                to++;
            end
            if (to >= 200) chk({tag, "_fetch_timeout"}, 64'(to), 64'd0);
            if (i == v.stall_idx) begin
                for (int s = 0; s < v.stall_len; s++) begin
                    chk({tag, "_stall_shift"}, 64'(shift_en), 64'd0);
                    tick();
                end
                chk({tag, "_stall_ready"}, 64'(cfg_ready), 64'd1);
            end
            cfg_valid = 1'b1;
            cfg_data  = v.words[i*W +: W];
            tick();
            cfg_valid = 1'b0;
            cfg_data  = W'($urandom);
            if (v.start_mid && i == 1) begin
                cfg_start = 1'b1;
                tick();
                cfg_start = 1'b0;
            end
        end
        to = 0;
        while (dones == base_dones && to < 4 * N + 100) begin
            tick();
            to++;
        end
        if (dones == base_dones) chk({tag, "_done_timeout"}, 64'(to), 64'd0);
        tick();
        tick();
        fault_at = -1;
        chk({tag, "_done_cnt"}, 64'(dones - base_dones), 64'd1);
        chk({tag, "_shifts"}, 64'(neg_shift - base_shift), 64'(v.exp_shifts));
        chk({tag, "_words"}, 64'(words_in - base_words), 64'(NW));
        chk({tag, "_done_lat"}, 64'(done_cyc - last_shift_cyc), 64'd1);
        chk({tag, "_err"}, 64'(err_at_done), 64'(v.exp_err));
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        if (v.fault_k < 0) chk({tag, "_image"}, 64'(chain), 64'(exp_image(v.words)));
    endtask

    localparam logic [NW*W-1:0] DEF_WORDS = 48'h02_81_00_FF_3C_A5;

    initial begin
        vec_t tbl[5];
        vec_t rv;
        int   base_dones, to, base_pos;
        logic [7:0] img8;

        tbl[0] = '{DEF_WORDS, 1'b0, -1, -1, 0, 1'b0, N,     1'b0};
        tbl[1] = '{DEF_WORDS, 1'b1, -1, -1, 0, 1'b0, 2 * N, 1'b0};
        tbl[2] = '{DEF_WORDS, 1'b1,  7, -1, 0, 1'b0, 2 * N, 1'b1};
        tbl[3] = '{DEF_WORDS, 1'b0, -1,  3, 10, 1'b0, N,    1'b0};
        tbl[4] = '{DEF_WORDS, 1'b1, -1, -1, 0, 1'b1, 2 * N, 1'b0};

        pReset    = 1'b1;
        cfg_start = 1'b1;
        repeat (3) tick();
        pReset    = 1'b0;
        cfg_start = 1'b0;
        chk("rst_ready", 64'(cfg_ready), 64'd0);
        chk("rst_head", 64'(ccff_head), 64'd0);
        chk("rst_shift", 64'(shift_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        cfg_valid = 1'b1;
        cfg_data  = 8'h5A;
        repeat (3) begin
            tick();
            chk("idle_ready", 64'(cfg_ready), 64'd0);
        end
        cfg_valid = 1'b0;
        chk("idle_words", 64'(words_in), 64'd0);
        chk("idle_shifts", 64'(neg_shift), 64'd0);

        for (int i = 0; i < 5; i++) run_session(tbl[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 8; r++) begin
            rv.words      = {16'($urandom), $urandom};
            rv.ver        = 1'($urandom);
            rv.fault_k    = (rv.ver && ($urandom_range(0, 2) == 0)) ? int'($urandom_range(0, N - 1)) : -1;
            rv.stall_idx  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NW - 1)) : -1;
            rv.stall_len  = $urandom_range(1, 12);
            rv.start_mid  = 1'($urandom);
            rv.exp_shifts = rv.ver ? 2 * N : N;
            rv.exp_err    = (rv.fault_k >= 0);
            run_session(rv, $sformatf("rnd%0d", r));
        end

        // Abort in the 20th shift cycle, with a same-cycle cfg_start that must lose to reset.
        base_dones = dones;
        base_pos   = pos_cnt;
        cfg_start  = 1'b1;
        verify_en  = 1'b1;
        tick();
        cfg_start  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to = 0;
            while (!cfg_ready && to < 100) begin
                tick();
                to++;
            end
            cfg_valid = 1'b1;
            cfg_data  = DEF_WORDS[i*W +: W];
            tick();
            cfg_valid = 1'b0;
        end
        to = 0;
        while ((pos_cnt - base_pos) < 19 && to < 100) begin
            tick();
            to++;
        end
        chk("abort_pos", 64'(pos_cnt - base_pos), 64'd19);
        chk("abort_in_shift", 64'(shift_en), 64'd1);
        pReset    = 1'b1;
        cfg_start = 1'b1;
        tick();
        pReset    = 1'b0;
        cfg_start = 1'b0;
        chk("abort_ready", 64'(cfg_ready), 64'd0);
        chk("abort_head", 64'(ccff_head), 64'd0);
        chk("abort_shift", 64'(shift_en), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        repeat (10) tick();
        chk("abort_no_done", 64'(dones - base_dones), 64'd0);
        chk("abort_still_idle", 64'(busy), 64'd0);
        chk("abort_partial", 64'(pos_cnt - base_pos), 64'd20);

        cfg_start8 = 1'b1;
        tick();
        cfg_start8 = 1'b0;
        to = 0;
        while (!cfg_ready8 && to < 50) begin
            tick();
            to++;
        end
        cfg_valid8 = 1'b1;
        cfg_data8  = 8'h6B;
        tick();
        cfg_valid8 = 1'b0;
        to = 0;
        while (dones8 == 0 && to < 100) begin
            tick();
            to++;
        end
        tick();
        for (int k = 0; k < 8; k++) img8[7-k] = cfg_data8[k];
        chk("p8_done", 64'(dones8), 64'd1);
        chk("p8_words", 64'(words8), 64'd1);
        chk("p8_shifts", 64'(shifts8), 64'd8);
        chk("p8_image", 64'(chain8), 64'(img8));
        chk("p8_idle", 64'(busy8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
